// File: rtl/uart_pkt_deframer_pkg.sv
// Shared types and constants for the UART packet deframer.
// Frame format on the wire: SOF, LEN (1..MAX_LEN), LEN payload bytes, CSUM,
// where CSUM = (LEN + sum of payload bytes) mod 256.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CSUM,
    DRAIN
  } state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CSUM    = 3'd2;
  localparam logic [2:0] ERR_PARITY  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_deframer_if.sv
// Bundles the UART rx FIFO side and the payload stream side of the deframer.
// master: the deframer. slave: whatever feeds the FIFO and consumes payload.
interface uart_pkt_deframer_if #(
  parameter int DATA_WIDTH = 8
);

  // UART rx FIFO (first-word-fall-through)
  logic                  rx_empty;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  incorrect_send;
  logic                  rd_uart;

  // Payload stream and error reporting
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;
  logic                  pkt_err;
  logic [2:0]            err_code;

  modport master (
    input  rx_empty, r_data, incorrect_send, out_ready,
    output rd_uart, out_valid, out_data, out_last, pkt_err, err_code
  );

  modport slave (
    output rx_empty, r_data, incorrect_send, out_ready,
    input  rd_uart, out_valid, out_data, out_last, pkt_err, err_code
  );

endinterface

// File: rtl/uart_pkt_deframer_buf.sv
// Payload register file: DEPTH x DATA_WIDTH, synchronous write, asynchronous
// read. Holds one frame's payload while its checksum is being verified.
module uart_pkt_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write one payload byte per cycle.
  // NOTE: storage has no reset; every entry a frame reads was written earlier
  // in that same frame, so reset would only add fan-out to every flop.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_pkt_deframer.sv
// UART packet deframer: pops bytes from the UART rx FIFO, hunts for SOF,
// collects LEN + payload + checksum, and streams verified payload out on a
// valid/ready byte interface. Bad frames raise a one-cycle pkt_err with a
// sticky err_code.
// Optional: define UART_PKT_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES
// idle cycles between bytes (err_code 4).
module uart_pkt_deframer
  import uart_pkt_pkg::*;
#(
  parameter int             DATA_WIDTH     = 8,
  parameter int             MAX_LEN        = 16,
  parameter logic [7:0]     SOF_BYTE       = SOF_DEFAULT
`ifdef UART_PKT_TIMEOUT_EN
  ,
  parameter int             TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic                    clk,
  input  logic                    Reset,
  uart_pkt_deframer_if.master     bus
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);
  localparam logic [DATA_WIDTH-1:0] SOF_B     = DATA_WIDTH'(SOF_BYTE);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;      // payload bytes still to collect
  logic [CW-1:0]         len_q, len_d;      // frame length, for out_last
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d; // next payload index to present
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  pkt_err_q, pkt_err_d;
  logic [2:0]            err_code_q, err_code_d;

  logic                  consume;
  logic                  buf_wr_en;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic                  load_out;
  logic                  raise_err;
  logic [2:0]            err_sel;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_q, idle_d;
`endif

  // Pop whenever a byte is waiting and we are collecting; never in DRAIN so
  // the UART FIFO absorbs downstream backpressure.
  assign bus.rd_uart = !bus.rx_empty &&
                       (state_q inside {HUNT, LEN, PAYLOAD, CSUM});
  assign consume     = bus.rd_uart;

  uart_pkt_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_LEN),
    .AW         (AW)
  ) u_pay_mem (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.r_data),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (buf_rd_data)
  );

  // Next-state, datapath and output decode for the frame FSM.
  // NOTE: every signal gets a default before the case, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;
    buf_wr_en   = 1'b0;
    load_out    = 1'b0;
    raise_err   = 1'b0;
    err_sel     = ERR_NONE;

    unique case (state_q)
      HUNT: begin
        // Parity on discarded bytes is irrelevant here.
        if (consume && bus.r_data == SOF_B) state_d = LEN;
      end

      LEN: begin
        if (consume) begin
          if (bus.incorrect_send) begin
            raise_err = 1'b1;
            err_sel   = ERR_PARITY;
          end else if (bus.r_data == '0 || bus.r_data > MAX_LEN_B) begin
            raise_err = 1'b1;
            err_sel   = ERR_LEN;
          end else begin
            cnt_d    = CW'(bus.r_data);
            len_d    = CW'(bus.r_data);
            sum_d    = bus.r_data;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (consume) begin
          if (bus.incorrect_send) begin
            raise_err = 1'b1;
            err_sel   = ERR_PARITY;
          end else begin
            buf_wr_en = 1'b1;
            wr_ptr_d  = wr_ptr_q + AW'(1);
            sum_d     = sum_q + bus.r_data;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = CSUM;
          end
        end
      end

      CSUM: begin
        if (consume) begin
          if (bus.incorrect_send) begin
            raise_err = 1'b1;
            err_sel   = ERR_PARITY;
          end else if (bus.r_data == sum_q) begin
            load_out = 1'b1;
            state_d  = DRAIN;
          end else begin
            raise_err = 1'b1;
            err_sel   = ERR_CSUM;
          end
        end
      end

      DRAIN: begin
        if (out_valid_q && bus.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = HUNT;
          end else begin
            load_out = 1'b1;
          end
        end
      end

      default: state_d = HUNT;
    endcase

`ifdef UART_PKT_TIMEOUT_EN
    // Inter-byte idle timer: runs only while a frame is half-collected.
    idle_d = '0;
    if ((state_q inside {LEN, PAYLOAD, CSUM}) && !consume) begin
      idle_d = idle_q + TW'(1);
      if (idle_d == TIMEOUT_VAL) begin
        idle_d    = '0;
        raise_err = 1'b1;
        err_sel   = ERR_TIMEOUT;
      end
    end
`endif

    // Present the payload byte at rd_ptr and step to the next one.
    if (load_out) begin
      out_valid_d = 1'b1;
      out_data_d  = buf_rd_data;
      out_last_d  = (rd_ptr_q == len_q - CW'(1));
      rd_ptr_d    = rd_ptr_q + CW'(1);
    end

    if (raise_err) begin
      pkt_err_d  = 1'b1;
      err_code_d = err_sel;
      state_d    = HUNT;
    end
  end

  // State, datapath and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
    end
  end

`ifdef UART_PKT_TIMEOUT_EN
  // Idle counter register.
  always_ff @(posedge clk) begin
    if (Reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.pkt_err   = pkt_err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Directed bench for uart_pkt_deframer. A queue models the UART rx FIFO;
// expected payload bytes and error codes go into scoreboards when frames are
// queued and are popped by a monitor when the DUT produces them.
module tb_uart_pkt_deframer;
  import uart_pkt_pkg::*;

  localparam int DW   = 8;
  localparam int MAXL = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } rx_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } out_t;

  logic clk = 1'b0;
  logic Reset;

  rx_t        rxq[$];
  out_t       exp_out[$];
  logic [2:0] exp_err[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_pkt_deframer_if #(.DATA_WIDTH(DW)) bus ();

  uart_pkt_deframer #(
    .DATA_WIDTH (DW),
    .MAX_LEN    (MAXL),
    .SOF_BYTE   (8'hA5)
`ifdef UART_PKT_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_raw(input logic [7:0] b, input logic par);
    rx_t r;
    r.data = b;
    r.par  = par;
    rxq.push_back(r);
  endtask

  // Queue a well-formed frame and its expected payload stream.
  task automatic good_frame(input logic [7:0] p[$]);
    logic [7:0] sum;
    out_t       o;
    sum = 8'(p.size());
    push_raw(8'hA5, 1'b0);
    push_raw(8'(p.size()), 1'b0);
    for (int i = 0; i < p.size(); i++) begin
      push_raw(p[i], 1'b0);
      sum = sum + p[i];
      o.data = p[i];
      o.last = (i == p.size() - 1);
      exp_out.push_back(o);
    end
    push_raw(sum, 1'b0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int   k;
    logic idle_ok;
    k = 0;
    while ((rxq.size() != 0 || exp_out.size() != 0 || exp_err.size() != 0 ||
            bus.out_valid === 1'b1) && k < budget) begin
      @(negedge clk);
      k++;
    end
    idle_ok = (k < budget);
    check(tag, idle_ok, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, bus.out_valid, 1'b1);
  endtask

  // UART rx FIFO model: decide the pop on the negedge, apply it after the edge.
  initial begin
    logic pop;
    bus.rx_empty       = 1'b1;
    bus.r_data         = '0;
    bus.incorrect_send = 1'b0;
    forever begin
      @(negedge clk);
      pop = bus.rd_uart;
      @(posedge clk);
      #1;
      if (pop === 1'b1 && rxq.size() > 0) void'(rxq.pop_front());
      if (rxq.size() > 0) begin
        bus.rx_empty       = 1'b0;
        bus.r_data         = rxq[0].data;
        bus.incorrect_send = rxq[0].par;
      end else begin
        bus.rx_empty       = 1'b1;
        bus.r_data         = '0;
        bus.incorrect_send = 1'b0;
      end
    end
  end

  // Output monitor: every transfer and every error pulse is scored.
  initial begin
    forever begin
      @(negedge clk);
      if (Reset === 1'b0) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (exp_out.size() == 0) begin
            check("unexpected_out", bus.out_valid, 1'b0);
          end else begin
            out_t e;
            e = exp_out.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_last", bus.out_last, e.last);
          end
        end
        if (bus.pkt_err === 1'b1) begin
          if (exp_err.size() == 0) begin
            check("unexpected_err", bus.pkt_err, 1'b0);
          end else begin
            logic [2:0] ec;
            ec = exp_err.pop_front();
            check("err_code", bus.err_code, ec);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] q[$];
    int         k;
    logic       win_ok;

    Reset         = 1'b1;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data",  bus.out_data,  8'h00);
    check("rst_out_last",  bus.out_last,  1'b0);
    check("rst_pkt_err",   bus.pkt_err,   1'b0);
    check("rst_err_code",  bus.err_code,  3'd0);
    check("rst_rd_uart",   bus.rd_uart,   1'b0);
    @(posedge clk);
    #1 Reset = 1'b0;

    // Good frame: 3 bytes on consecutive cycles, then out_valid drops
    q = '{8'h11, 8'h22, 8'h33};
    good_frame(q);
    wait_valid("good_valid");
    for (int i = 0; i < 3; i++) begin
      check("good_burst_valid", bus.out_valid, 1'b1);
      @(negedge clk);
    end
    check("good_burst_end", bus.out_valid, 1'b0);
    wait_done("good_done", 200);

    // Junk before SOF is discarded
    push_raw(8'h00, 1'b0);
    push_raw(8'hFF, 1'b0);
    q = '{8'h7E};
    good_frame(q);
    wait_done("junk_done", 200);
    check("junk_fifo_empty", rxq.size(), 0);

    // Bad checksum, then a good frame
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    foreach (q[i]) push_raw(q[i], 1'b0);
    exp_err.push_back(ERR_CSUM);
    wait_done("csum_done", 200);
    check("csum_code_held", bus.err_code, 3'd2);
    q = '{8'h01, 8'h02};
    good_frame(q);
    wait_done("after_csum_done", 200);

    // Length errors: zero and MAX_LEN+1
    push_raw(8'hA5, 1'b0);
    push_raw(8'h00, 1'b0);
    exp_err.push_back(ERR_LEN);
    wait_done("len0_done", 200);
    push_raw(8'hA5, 1'b0);
    push_raw(8'h11, 1'b0);
    exp_err.push_back(ERR_LEN);
    wait_done("len17_done", 200);

    // Parity on the 2nd payload byte; trailing bytes fall into HUNT
    q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    foreach (q[i]) push_raw(q[i], (i == 3));
    exp_err.push_back(ERR_PARITY);
    wait_done("par_payload_done", 200);
    check("par_code_held", bus.err_code, 3'd3);

    // Parity beats length error on the LEN byte
    push_raw(8'hA5, 1'b0);
    push_raw(8'h00, 1'b1);
    exp_err.push_back(ERR_PARITY);
    wait_done("par_len_done", 200);

    // Parity beats checksum error on the CSUM byte
    push_raw(8'hA5, 1'b0);
    push_raw(8'h01, 1'b0);
    push_raw(8'h10, 1'b0);
    push_raw(8'h00, 1'b1);
    exp_err.push_back(ERR_PARITY);
    wait_done("par_csum_done", 200);

    // Maximum-length frame
    q.delete();
    for (int i = 0; i < MAXL; i++) q.push_back(8'(i * 17 + 3));
    good_frame(q);
    wait_done("maxlen_done", 300);

    // Backpressure: data holds, no pops while the FIFO still has bytes
    bus.out_ready = 1'b0;
    q = '{8'hAA, 8'hBB, 8'hCC};
    good_frame(q);
    push_raw(8'h55, 1'b0);
    push_raw(8'h66, 1'b0);
    wait_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      check("bp_out_data", bus.out_data, 8'hAA);
      check("bp_out_last", bus.out_last, 1'b0);
      check("bp_rd_uart",  bus.rd_uart,  1'b0);
      @(negedge clk);
    end
    check("bp_fifo_held", rxq.size(), 2);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_done("bp_done", 200);

    // Reset after 2 of 3 payload bytes
    q = '{8'hA5, 8'h03, 8'h11, 8'h22};
    foreach (q[i]) push_raw(q[i], 1'b0);
    k = 0;
    while (rxq.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("mid_fifo_drained", rxq.size(), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 Reset = 1'b1;
    @(posedge clk);
    #1 Reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid",   bus.out_valid, 1'b0);
    check("mid_rst_pkt_err", bus.pkt_err,   1'b0);
    repeat (3) @(negedge clk);
    check("mid_rst_idle", bus.out_valid, 1'b0);
    q = '{8'h5A, 8'hC3};
    good_frame(q);
    wait_done("after_rst_done", 200);

`ifdef UART_PKT_TIMEOUT_EN
    // Stall after the LEN byte: timeout fires 100 cycles after it is consumed
    push_raw(8'hA5, 1'b0);
    push_raw(8'h02, 1'b0);
    exp_err.push_back(ERR_TIMEOUT);
    k = 0;
    while (rxq.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (bus.pkt_err !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    win_ok = (k >= 98 && k <= 101);
    check("timeout_window", win_ok, 1'b1);
    wait_done("timeout_done", 50);
`else
    win_ok = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_pkt_deframer.md
Name: uart_pkt_deframer

Overview:
- Downstream consumer of the UART receive FIFO.
- Pops received bytes, hunts for a start-of-frame byte, and collects a length-prefixed payload plus an 8-bit checksum into an internal buffer.
- Once the frame is verified, streams the payload out on a valid/ready byte interface; bad frames are dropped with an error code.
- Sits between the UART top (r_data/rd_uart/rx_empty/incorrect_send) and the host command logic.

Parameters:
- Data_width, 8, byte width; matches UART data bits excluding parity.
- Max_len, 16, maximum payload bytes; legal LEN is 1..Max_len.
- Sof_byte, 8'hA5, start-of-frame marker.
- Timeout_cycles, 2000000, inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- rx_empty  in  1  UART rx FIFO empty.
- r_data  in  Data_width  head of the UART rx FIFO; first-word-fall-through, valid while rx_empty=0.
- incorrect_send  in  1  parity error flag for the byte currently at r_data.
- rd_uart  out  1  pop strobe to the UART rx FIFO.
- out_valid  out  1  payload byte valid.
- out_data  out  Data_width  payload byte.
- out_last  out  1  final payload byte of the frame.
- out_ready  in  1  downstream accepts the byte.
- pkt_err  out  1  one-cycle error pulse.
- err_code  out  3  error cause; holds its value until the next pkt_err.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: rd_uart=0, out_valid=0, out_data=0, out_last=0, pkt_err=0, err_code=0. State=HUNT; internal count and sum are cleared.
- Pop rule: rd_uart = !rx_empty && state in {HUNT, LEN, PAYLOAD, CSUM}. This is combinational from state and rx_empty, giving at most one pop per cycle. A byte counts as consumed on the cycle rd_uart=1, when r_data and incorrect_send are sampled.
- HUNT: a consumed byte equal to Sof_byte moves to LEN. Any other byte is silently discarded.
- LEN: consumed byte L.
  - L==0 or L>Max_len: pkt_err, err_code=1, go to HUNT.
  - Otherwise: cnt=L, sum=L, wr_ptr=0, go to PAYLOAD.
- PAYLOAD: each consumed byte goes to buf[wr_ptr]; wr_ptr++, sum = (sum + byte) mod 256. After the L-th byte, go to CSUM.
- CSUM: consumed byte C.
  - C==sum: rd_ptr=0, go to DRAIN.
  - Otherwise: pkt_err, err_code=2, go to HUNT.
- Parity: if incorrect_send=1 on any consumed byte in LEN, PAYLOAD or CSUM: pkt_err, err_code=3, go to HUNT. Parity takes priority over length and checksum errors. A parity error in HUNT is ignored and the byte is discarded.
- DRAIN:
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==L-1). All are registered outputs.
  - A transfer occurs when out_valid && out_ready; rd_ptr then advances.
  - Transfer with out_last=1: out_valid drops on the next cycle and state returns to HUNT.
  - While out_ready=0, out_data and out_last hold stable.
  - rd_uart=0 throughout DRAIN, so the UART FIFO absorbs backpressure.
- Latency: first out_valid appears 1 cycle after the CSUM byte is consumed.
- No frame overlap: a new SOF is not searched for until DRAIN completes.
- Reset mid-frame: the partial frame is discarded. No pkt_err is raised and out_valid is 0 on the next cycle.
- Byte width: all arithmetic is Data_width-bit with wrap; cnt and pointers are $clog2(Max_len+1) bits.

Optional Feature:
- Macro: UART_PKT_TIMEOUT_EN.
- Defined: an idle counter increments each cycle in LEN, PAYLOAD or CSUM with no byte consumed, and clears on every consumed byte. Reaching Timeout_cycles gives pkt_err, err_code=4, go to HUNT.
- Undefined: no counter exists; the block waits indefinitely for the next byte. Code 4 is never produced.

Decomposition:
- Package uart_pkt_pkg holds:
  - state enum {HUNT, LEN, PAYLOAD, CSUM, DRAIN};
  - err_code constants ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2, ERR_PARITY=3, ERR_TIMEOUT=4;
  - default SOF constant.
- One sub-module, uart_pkt_buf: Max_len x Data_width register file with a synchronous write port and an asynchronous read port (wr_en, wr_addr, wr_data, rd_addr, rd_data). Its storage is not reset.

Test Plan:
- Good frame: bytes A5 03 11 22 33 69, out_ready=1 -> out_data 11, 22, 33 on consecutive cycles; out_last only on 33; no pkt_err.
- Junk before SOF: 00 FF A5 01 7E 7F -> the two junk bytes are discarded; single byte 7E with out_last=1.
- Bad checksum: A5 03 11 22 33 6A -> pkt_err pulse, err_code=2, out_valid never asserts. A following good frame is then delivered.
- Length errors: A5 00 -> err_code=1. A5 11 (17>16) -> err_code=1.
- Parity and backpressure:
  - incorrect_send=1 on the 2nd payload byte -> err_code=3.
  - Good frame with out_ready low for 5 cycles -> out_data holds and rd_uart=0 while rx_empty=0.
- Reset after 2 of 3 payload bytes -> no output, no pkt_err; the next good frame is delivered. With UART_PKT_TIMEOUT_EN and Timeout_cycles=100, stalling after the LEN byte -> err_code=4 at cycle 100.
